ps_mm_reader: RTL and testbench
===============================

Name: ps_mm_reader

Overview:
- Reads a block of symbols from Avalon-MM memory on command and emits it as one PacketStream packet (dat/mty/val/eop/rdy).
- Read-side counterpart of the packet-to-memory writer. Uses the same word addressing: address +1 per DWIDTH word. Uses the same mty convention: count of empty high-order symbols in the eop word.
- Pipelined reads with readdatavalid.
- A credit scheme bounds outstanding reads to the internal buffer depth, so output backpressure never loses data.

Parameters:
- DWIDTH, 8: data width; equals SYMBOLS * symbol width.
- AWIDTH, 8: Avalon word-address width.
- SYMBOLS, 4: symbols per word; power of 2, ≥ 2.
- LWIDTH, 16: width of command length field, in symbols.
- DEPTH, 4: max outstanding reads plus buffered words; power of 2, ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_address  in  AWIDTH  start word address.
- cmd_length  in  LWIDTH  packet length in symbols.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- busy  out  1  packet in progress.
- o_dat  out  DWIDTH  output data.
- o_mty  out  $clog2(SYMBOLS)  empty high symbols; meaningful only with o_eop.
- o_val  out  1  output valid.
- o_eop  out  1  last word of packet.
- o_rdy  in  1  downstream ready.
- avm_address  out  AWIDTH  read word address.
- avm_byteenable  out  SYMBOLS  constant all ones.
- avm_read  out  1  read request.
- avm_readdata  in  DWIDTH  read data.
- avm_readdatavalid  in  1  read data valid; responses arrive in order.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset values: cmd_ready=1, busy=0, o_val=0, o_eop=0, o_mty=0, o_dat=0, avm_read=0, avm_address=0. All counters and the buffer are cleared.
- Word count: W = ceil(L/SYMBOLS), computed at acceptance.
- Last-word empty count: mty = (SYMBOLS − L mod SYMBOLS) mod SYMBOLS.
  - L=10, SYMBOLS=4: W=3, mty=2.
- L=0: the command is accepted. No reads and no output are generated. cmd_ready stays 1.
- Command acceptance (L≠0):
  - Latch the address as the read pointer.
  - Latch W into an issue counter and an output counter.
  - cmd_ready→0 and busy→1 from the next cycle.
- FSM:
  - IDLE: cmd_ready=1. A valid command with L≠0 → READ.
  - READ: avm_read=1 whenever credit > 0.
    - A read is issued when avm_read & ~avm_waitrequest.
    - On issue: pointer +1 (wraps modulo 2^AWIDTH), issue counter −1, credit −1.
    - Last issue → DRAIN.
  - DRAIN: avm_read=0. Wait until the output counter reaches 0 → IDLE, with cmd_ready=1 on the following cycle.
- avm_address and avm_read are held stable while avm_waitrequest=1.
- avm_read only drops while stalled if that is forced by reset.
- Credit accounting:
  - Credit starts at DEPTH.
  - Decrements on each issued read.
  - Increments on each output handshake (o_val & o_rdy).
  - Simultaneous issue and handshake leave credit unchanged.
  - This guarantees the buffer never overflows, whatever the read latency.
- Buffer: FIFO of DEPTH words, written on avm_readdatavalid.
  - Data returned while IDLE (stale, e.g. after reset) is dropped.
  - The output is the FIFO head, registered (first-word fall-through). Minimum latency from readdatavalid to o_val is 1 cycle.
- Output:
  - o_val = FIFO not empty.
  - o_eop=1 when the output counter is 1; o_mty is driven with the latched mty.
  - o_dat, o_eop and o_mty stay stable while o_val & ~o_rdy.
  - Output counter decrements on each handshake.
- Throughput: one word per cycle sustained when waitrequest=0, o_rdy=1 and read latency < DEPTH.
- Back-to-back commands: the next command is accepted only after the last word handshake. There is a single packet in flight.
- Reset mid-packet: the FSM returns to IDLE immediately and the FIFO is flushed. The Avalon slave is expected to share the same reset.

Test Plan:
- SYMBOLS=4, cmd_address=0x10, L=8, fixed read latency 2, o_rdy=1 → reads at 0x10, 0x11. Two words out; eop on the second with mty=0. cmd_ready returns 1.
- L=10, address 0x20 → 3 reads (0x20–0x22). Third word has o_eop=1, o_mty=2. L=1 → 1 word, mty=3.
- Address 0xFE, AWIDTH=8, L=16 → reads 0xFE, 0xFF, 0x00, 0x01 (wrap).
- o_rdy=0 throughout, L=40 (W=10), DEPTH=4 → exactly 4 reads issued, then avm_read=0. After o_rdy=1, all 10 words arrive in order with no loss.
- Random avm_waitrequest and latency 1–6, L=37 → address and read held during stall. Data matches the memory model. Exactly 10 words; mty=3.
- Reset asserted mid-packet after 2 reads → outputs return to reset values. Late readdatavalid is ignored. A following L=4 command yields exactly 1 clean word.

Source files
------------

// File: rtl/ps_mm_reader.sv
// Avalon-MM block reader: fetches ceil(L/SYMBOLS) words and emits them as one PacketStream packet.
// Output follows readdatavalid by >=1 cycle; read credits cap in-flight words at DEPTH so a stalled o_rdy never drops data.

module ps_mm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CAP = 1'b1 << PW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push & (count != CAP);
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ps_mm_reader #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int SYMBOLS = 4,
  parameter int LWIDTH  = 16,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AWIDTH-1:0]          cmd_address,
  input  logic [LWIDTH-1:0]          cmd_length,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic                       busy,
  output logic [DWIDTH-1:0]          o_dat,
  output logic [$clog2(SYMBOLS)-1:0] o_mty,
  output logic                       o_val,
  output logic                       o_eop,
  input  logic                       o_rdy,
  output logic [AWIDTH-1:0]          avm_address,
  output logic [SYMBOLS-1:0]         avm_byteenable,
  output logic                       avm_read,
  input  logic [DWIDTH-1:0]          avm_readdata,
  input  logic                       avm_readdatavalid,
  input  logic                       avm_waitrequest
);
  localparam int MW = $clog2(SYMBOLS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CREDIT_INIT = 1'b1 << (CW - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  state_t            state_next;
  logic [AWIDTH-1:0] ptr;
  logic [LWIDTH-1:0] issue_cnt;
  logic [LWIDTH-1:0] out_cnt;
  logic [CW-1:0]     credit;
  logic [MW-1:0]     mty_q;
  logic [LWIDTH-1:0] words;
  logic [MW-1:0]     len_lo;
  logic [MW-1:0]     last_mty;
  logic              start;
  logic              issue;
  logic              hs;
  logic              fifo_empty;

  assign len_lo   = cmd_length[MW-1:0];
  assign words    = (cmd_length >> MW) + LWIDTH'(|len_lo);
  assign last_mty = '0 - len_lo;
  assign start    = cmd_valid & cmd_ready & (cmd_length != '0);
  assign issue    = avm_read & ~avm_waitrequest;
  assign hs       = o_val & o_rdy;

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    avm_read   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (start) state_next = READ;
      end
      READ: begin
        // credit only falls on an issue, so a stalled request stays asserted
        avm_read = (credit != '0);
        if (issue && issue_cnt == LWIDTH'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_cnt == '0 || (hs && out_cnt == LWIDTH'(1))) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      issue_cnt <= '0;
      out_cnt   <= '0;
      credit    <= CREDIT_INIT;
      mty_q     <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        ptr       <= cmd_address;
        issue_cnt <= words;
        out_cnt   <= words;
        mty_q     <= last_mty;
      end else begin
        if (issue) begin
          ptr       <= ptr + AWIDTH'(1);
          issue_cnt <= issue_cnt - LWIDTH'(1);
        end
        if (hs) out_cnt <= out_cnt - LWIDTH'(1);
      end
      case ({issue, hs})
        2'b10:   credit <= credit - CW'(1);
        2'b01:   credit <= credit + CW'(1);
        default: credit <= credit;
      endcase
    end
  end

  // responses landing while idle are leftovers from before a reset
  ps_mm_fifo #(.WIDTH(DWIDTH), .DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (avm_readdatavalid & (state != IDLE)),
    .push_dat (avm_readdata),
    .pop      (hs),
    .head     (o_dat),
    .empty    (fifo_empty)
  );

  assign o_val          = ~fifo_empty;
  assign o_eop          = o_val & (out_cnt == LWIDTH'(1));
  assign o_mty          = mty_q;
  assign avm_address    = ptr;
  assign avm_byteenable = '1;
endmodule

// File: tb/tb_ps_mm_reader.sv
// Bench for ps_mm_reader: Avalon slave model with in-order variable latency, scoreboard from address/length arithmetic.
module tb_ps_mm_reader;
  logic       clk;
  logic       reset;
  logic [7:0] cmd_address;
  logic [15:0] cmd_length;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic [7:0] o_dat;
  logic [1:0] o_mty;
  logic       o_val;
  logic       o_eop;
  logic       o_rdy;
  logic [7:0] avm_address;
  logic [3:0] avm_byteenable;
  logic       avm_read;
  logic [7:0] avm_readdata;
  logic       avm_readdatavalid;
  logic       avm_waitrequest;

  ps_mm_reader #(.DWIDTH(8), .AWIDTH(8), .SYMBOLS(4), .LWIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_address(cmd_address), .cmd_length(cmd_length), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .busy(busy),
    .o_dat(o_dat), .o_mty(o_mty), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  typedef struct {
    logic [7:0] dat;
    logic       eop;
    logic [1:0] mty;
    int         cyc;
  } word_t;

  typedef struct {
    logic [7:0] addr;
    int         due;
  } rd_t;

  typedef struct {
    logic [7:0] addr;
    int         len;
    int         w;
    int         mty;
    int         rmode;
    int         lmode;
    bit         ws;
    bit         perf;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_due = 0;
  int fix_lat = 2;
  int rdy_mode = 0;
  int lat_mode = 0;
  bit ws_mode = 0;

  logic [7:0] mem [256];
  rd_t        pend_q[$];
  logic [7:0] iss_q[$];
  word_t      out_q[$];
  vec_t       vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Avalon slave + output monitor, all decisions at negedge for the following posedge
  initial begin
    int lat;
    int d;
    logic       prev_ostall;
    logic       prev_astall;
    logic [7:0] p_dat;
    logic       p_eop;
    logic [1:0] p_mty;
    logic [7:0] p_addr;
    word_t      w;
    rd_t        r;
    prev_ostall = 0;
    prev_astall = 0;
    p_dat = 0; p_eop = 0; p_mty = 0; p_addr = 0;
    o_rdy = 0;
    avm_readdatavalid = 0;
    avm_readdata = 0;
    avm_waitrequest = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_ostall = 0;
        prev_astall = 0;
      end else begin
        if (prev_ostall) begin
          chk("hold o_val", o_val, 1);
          chk("hold o_dat", o_dat, p_dat);
          chk("hold o_eop", o_eop, p_eop);
          chk("hold o_mty", o_mty, p_mty);
        end
        if (prev_astall) begin
          chk("hold avm_read", avm_read, 1);
          chk("hold avm_address", avm_address, p_addr);
        end
      end
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        avm_readdatavalid = 1;
        avm_readdata = mem[pend_q[0].addr];
        void'(pend_q.pop_front());
      end else begin
        avm_readdatavalid = 0;
        avm_readdata = 8'($urandom);
      end
      avm_waitrequest = ws_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (!reset && avm_read && !avm_waitrequest) begin
        lat = (lat_mode == 0) ? fix_lat : int'($urandom_range(1, 6));
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        r.addr = avm_address;
        r.due = d;
        pend_q.push_back(r);
        iss_q.push_back(avm_address);
      end
      prev_astall = !reset && avm_read && avm_waitrequest;
      p_addr = avm_address;
      case (rdy_mode)
        0:       o_rdy = 1;
        1:       o_rdy = 1'($urandom_range(0, 1));
        default: o_rdy = 0;
      endcase
      if (!reset && o_val && o_rdy) begin
        w.dat = o_dat; w.eop = o_eop; w.mty = o_mty; w.cyc = cyc;
        out_q.push_back(w);
      end
      prev_ostall = !reset && o_val && !o_rdy;
      p_dat = o_dat; p_eop = o_eop; p_mty = o_mty;
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " o_val"}, o_val, 0);
    chk({tag, " o_eop"}, o_eop, 0);
    chk({tag, " o_mty"}, o_mty, 0);
    chk({tag, " o_dat"}, o_dat, 0);
    chk({tag, " avm_read"}, avm_read, 0);
    chk({tag, " avm_address"}, avm_address, 0);
    chk({tag, " byteenable"}, avm_byteenable, 4'hF);
  endtask

  task automatic send_cmd(input logic [7:0] a, input int len, input string tag);
    @(negedge clk); #1;
    chk({tag, " ready before cmd"}, cmd_ready, 1);
    cmd_address = a;
    cmd_length = 16'(len);
    cmd_valid = 1;
    @(negedge clk); #1;
    cmd_valid = 0;
    chk({tag, " busy after cmd"}, busy, len != 0);
    chk({tag, " cmd_ready after cmd"}, cmd_ready, len == 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, " done in budget"}, busy, 0);
    repeat (4) @(negedge clk);
    #1;
    chk({tag, " cmd_ready at end"}, cmd_ready, 1);
  endtask

  task automatic check_words(input logic [7:0] base, input int w, input int mty, input bit perf,
                             input string tag);
    logic [7:0] a;
    chk({tag, " read count"}, iss_q.size(), w);
    chk({tag, " word count"}, out_q.size(), w);
    for (int i = 0; i < w; i++) begin
      a = base + 8'(i);
      if (i < iss_q.size()) chk({tag, " read address"}, iss_q[i], a);
      if (i < out_q.size()) begin
        chk({tag, " data"}, out_q[i].dat, mem[a]);
        chk({tag, " eop"}, out_q[i].eop, i == w - 1);
        if (i == w - 1) chk({tag, " mty"}, out_q[i].mty, mty);
        if (perf) chk({tag, " one word per cycle"}, out_q[i].cyc, out_q[0].cyc + i);
      end
    end
  endtask

  task automatic clear_q();
    iss_q.delete();
    out_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    logic [7:0] a;
    reset = 1;
    cmd_address = 0;
    cmd_length = 0;
    cmd_valid = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    //          addr   len  W   mty rmode lmode ws  perf
    vecs[0] = '{8'h10,  8,  2,  0,  0,    0,    0,  0};
    vecs[1] = '{8'h20, 10,  3,  2,  0,    0,    0,  0};
    vecs[2] = '{8'h30,  1,  1,  3,  0,    0,    0,  0};
    vecs[3] = '{8'hFE, 16,  4,  0,  0,    0,    0,  1};
    vecs[4] = '{8'h50, 37, 10,  3,  1,    1,    1,  0};
    vecs[5] = '{8'h60,  0,  0,  0,  0,    0,    0,  0};
    vecs[6] = '{8'h70,  4,  1,  0,  1,    0,    0,  0};
    vecs[7] = '{8'h90, 64, 16,  0,  0,    0,    0,  1};

    @(negedge clk); #1;
    chk_reset_vals("reset");
    @(negedge clk); #1;
    reset = 0;

    for (int v = 0; v < 8; v++) begin
      rdy_mode = vecs[v].rmode;
      lat_mode = vecs[v].lmode;
      ws_mode = vecs[v].ws;
      fix_lat = 2;
      clear_q();
      send_cmd(vecs[v].addr, vecs[v].len, $sformatf("vec%0d", v));
      if (vecs[v].len == 0) begin
        repeat (6) @(negedge clk);
        #1;
        chk("len0 reads", iss_q.size(), 0);
        chk("len0 words", out_q.size(), 0);
        chk("len0 busy", busy, 0);
        chk("len0 cmd_ready", cmd_ready, 1);
      end else begin
        wait_done($sformatf("vec%0d", v));
        check_words(vecs[v].addr, vecs[v].w, vecs[v].mty, vecs[v].perf, $sformatf("vec%0d", v));
      end
    end

    // output stalled throughout: credits must stop reads at DEPTH
    rdy_mode = 2; lat_mode = 0; ws_mode = 0; fix_lat = 2;
    clear_q();
    send_cmd(8'hA0, 40, "bp");
    repeat (30) @(negedge clk);
    #1;
    chk("bp reads while stalled", iss_q.size(), 4);
    chk("bp avm_read dropped", avm_read, 0);
    chk("bp o_val", o_val, 1);
    chk("bp no words", out_q.size(), 0);
    rdy_mode = 0;
    wait_done("bp");
    check_words(8'hA0, 10, 0, 0, "bp");

    // random packets against arithmetic model
    for (int k = 0; k < 6; k++) begin
      len = int'($urandom_range(1, 60));
      a = 8'($urandom);
      rdy_mode = 1; lat_mode = 1; ws_mode = 1;
      clear_q();
      send_cmd(a, len, $sformatf("rnd%0d", k));
      wait_done($sformatf("rnd%0d", k));
      check_words(a, (len + 3) / 4, (4 - len % 4) % 4, 0, $sformatf("rnd%0d L=%0d", k, len));
    end

    // reset mid-packet with responses still in flight
    rdy_mode = 0; lat_mode = 0; ws_mode = 0; fix_lat = 4;
    clear_q();
    send_cmd(8'h40, 32, "rst");
    n = 0;
    while (iss_q.size() < 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #2;
    reset = 1;
    #1;
    chk_reset_vals("midrst");
    chk("midrst late data pending", pend_q.size() > 0, 1);
    @(negedge clk);
    @(negedge clk); #1;
    reset = 0;
    out_q.delete();
    n = 0;
    while (pend_q.size() > 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("midrst stale drained", pend_q.size(), 0);
    chk("midrst stale words", out_q.size(), 0);
    chk("midrst o_val", o_val, 0);
    chk("midrst busy", busy, 0);
    fix_lat = 2;
    clear_q();
    send_cmd(8'h80, 4, "postrst");
    wait_done("postrst");
    check_words(8'h80, 1, 0, 0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
